// File: rtl/pio_key_debounce_irq.sv
// Key-input PIO: 2-flop synchroniser, per-channel debounce counter, edge capture
// with rise/fall qualification and a maskable level interrupt behind a small register map.
module pio_key_debounce_irq #(
   parameter int               WIDTH           = 4,
   parameter int               DEBOUNCE_CYCLES = 16,
   parameter logic [WIDTH-1:0] RESET_LEVEL     = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sync1_r;
   logic [WIDTH-1:0] sync2_r;
   logic [WIDTH-1:0] stable_r;
   logic [WIDTH-1:0] irq_mask_r;
   logic [WIDTH-1:0] edge_capture_r;
   logic [WIDTH-1:0] rise_en_r;
   logic [WIDTH-1:0] fall_en_r;
   logic [31:0]      readdata_r;
   logic [CW-1:0]    count_r     [WIDTH];

   logic [CW-1:0]    count_nxt_s [WIDTH];
   logic [WIDTH-1:0] stable_nxt_s;
   logic [WIDTH-1:0] capture_set_s;
   logic [WIDTH-1:0] capture_clr_s;
   logic [WIDTH-1:0] capture_nxt_s;
   logic [31:0]      rd_s;
   logic             wr_en_s;
   logic             irq_s;
   logic             unused_ok_s;

   assign wr_en_s     = chipselect & ~write_n;
   assign irq_s       = |(edge_capture_r & irq_mask_r);
   assign unused_ok_s = &{1'b0, writedata};

   // Debounce: a channel accepts sync2 once it has differed from stable for DEBOUNCE_CYCLES edges
   always_comb begin
      stable_nxt_s  = stable_r;
      capture_set_s = '0;
      for (int i = 0; i < WIDTH; i++) begin
         count_nxt_s[i] = count_r[i];
         if (sync2_r[i] == stable_r[i]) begin
            count_nxt_s[i] = '0;
         end else if (count_r[i] == CNT_LAST) begin
            stable_nxt_s[i]  = sync2_r[i];
            count_nxt_s[i]   = '0;
            capture_set_s[i] = sync2_r[i] ? rise_en_r[i] : fall_en_r[i];
         end else begin
            count_nxt_s[i] = count_r[i] + 1'b1;
         end
      end
   end

   // Edge capture update; a same-cycle set wins over a write-1-to-clear
   always_comb begin
      if (wr_en_s && (address == 3'd3)) begin
         capture_clr_s = writedata[WIDTH-1:0];
      end else begin
         capture_clr_s = '0;
      end
      capture_nxt_s = (edge_capture_r & ~capture_clr_s) | capture_set_s;
   end

   // Read mux, zero-extended to the bus width
   always_comb begin
      rd_s = 32'h0;
      case (address)
         3'd0:    rd_s[WIDTH-1:0] = stable_r;
         3'd1:    rd_s[WIDTH-1:0] = sync2_r;
         3'd2:    rd_s[WIDTH-1:0] = irq_mask_r;
         3'd3:    rd_s[WIDTH-1:0] = edge_capture_r;
         3'd4:    rd_s[WIDTH-1:0] = rise_en_r;
         3'd5:    rd_s[WIDTH-1:0] = fall_en_r;
         3'd6:    rd_s[0]         = irq_s;
         default: rd_s            = 32'h0;
      endcase
   end

   // Input synchroniser, debounce state and edge capture
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_r        <= RESET_LEVEL;
         sync2_r        <= RESET_LEVEL;
         stable_r       <= RESET_LEVEL;
         edge_capture_r <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            count_r[i] <= '0;
         end
      end else begin
         sync1_r        <= in_port;
         sync2_r        <= sync1_r;
         stable_r       <= stable_nxt_s;
         edge_capture_r <= capture_nxt_s;
         for (int i = 0; i < WIDTH; i++) begin
            count_r[i] <= count_nxt_s[i];
         end
      end
   end

   // Software-writable control registers; falls are enabled out of reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_mask_r <= '0;
         rise_en_r  <= '0;
         fall_en_r  <= {WIDTH{1'b1}};
      end else if (wr_en_s) begin
         case (address)
            3'd2:    irq_mask_r <= writedata[WIDTH-1:0];
            3'd4:    rise_en_r  <= writedata[WIDTH-1:0];
            3'd5:    fall_en_r  <= writedata[WIDTH-1:0];
            default: irq_mask_r <= irq_mask_r;
         endcase
      end else begin
         irq_mask_r <= irq_mask_r;
      end
   end

   // Read data is registered every cycle independent of chipselect
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata_r <= 32'h0;
      end else begin
         readdata_r <= rd_s;
      end
   end

   assign readdata = readdata_r;
   assign irq      = irq_s;

endmodule

// File: tb/tb_pio_key_debounce_irq.sv
// Scoreboard bench for pio_key_debounce_irq: directed scenarios plus random traffic,
// checked against a run-length behavioural model of the debounce and register map.
module tb_pio_key_debounce_irq;

   localparam int D = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [3:0]  in_port;
   logic [31:0] readdata;
   logic        irq;

   int checks = 0;
   int errors = 0;

   logic [31:0] sb[$];
   logic [3:0]  m_s1, m_s2, m_stable, m_mask, m_cap, m_rise, m_fall;
   int          m_run[4];
   logic [3:0]  cur_pin;

   pio_key_debounce_irq #(.WIDTH(4), .DEBOUNCE_CYCLES(D), .RESET_LEVEL(4'hF)) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(readdata), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_s1 = 4'hF; m_s2 = 4'hF; m_stable = 4'hF;
      m_mask = 4'h0; m_cap = 4'h0; m_rise = 4'h0; m_fall = 4'hF;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
      sb.delete();
   endtask

   // One clock edge of the reference: a level is accepted after D consecutive differing edges
   task automatic model_step();
      logic [31:0] rd;
      logic [3:0]  set, clr, nstable;
      logic        wr;
      case (address)
         3'd0: rd = {28'h0, m_stable};
         3'd1: rd = {28'h0, m_s2};
         3'd2: rd = {28'h0, m_mask};
         3'd3: rd = {28'h0, m_cap};
         3'd4: rd = {28'h0, m_rise};
         3'd5: rd = {28'h0, m_fall};
         3'd6: rd = {31'h0, |(m_cap & m_mask)};
         default: rd = 32'h0;
      endcase
      sb.push_back(rd);
      set = 4'h0;
      nstable = m_stable;
      for (int i = 0; i < 4; i++) begin
         if (m_s2[i] != m_stable[i]) begin
            m_run[i]++;
            if (m_run[i] == D) begin
               nstable[i] = m_s2[i];
               m_run[i] = 0;
               set[i] = m_s2[i] ? m_rise[i] : m_fall[i];
            end
         end else begin
            m_run[i] = 0;
         end
      end
      wr  = chipselect && !write_n;
      clr = (wr && address == 3'd3) ? writedata[3:0] : 4'h0;
      m_cap = (m_cap & ~clr) | set;
      if (wr && address == 3'd2) m_mask = writedata[3:0];
      if (wr && address == 3'd4) m_rise = writedata[3:0];
      if (wr && address == 3'd5) m_fall = writedata[3:0];
      m_stable = nstable;
      m_s2 = m_s1;
      m_s1 = in_port;
   endtask

   task automatic tick(input logic c, input logic w, input logic [2:0] a, input logic [31:0] d,
                       input logic r);
      @(negedge clk);
      chipselect = c; write_n = w; address = a; writedata = d; in_port = cur_pin; reset_n = r;
      @(posedge clk);
      if (reset_n) model_step();
      else model_reset();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) tick(1'b1, 1'b1, 3'd0, 32'h0, 1'b1);
   endtask

   task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
      tick(1'b1, 1'b0, a, d, 1'b1);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic rd_chk(input logic [2:0] a, input logic [31:0] exp, input string name);
      tick(1'b1, 1'b1, a, 32'h0, 1'b1);
      #1 chk(name, readdata, exp);
   endtask

   // Monitor: readdata is presented every cycle; pop one expectation per cycle
   always @(negedge clk) begin
      if (!reset_n) begin
         chk("reset_readdata", readdata, 32'h0);
         chk("reset_irq", {31'h0, irq}, 32'h0);
      end else begin
         if (sb.size() > 0) chk("sb_readdata", readdata, sb.pop_front());
         chk("sb_irq", {31'h0, irq}, {31'h0, |(m_cap & m_mask)});
      end
   end

   initial begin
      cur_pin = 4'hF;
      chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = 32'h0;
      in_port = 4'hF; reset_n = 1'b0;
      model_reset();
      for (int k = 0; k < 3; k++) tick(1'b0, 1'b1, 3'd0, 32'h0, 1'b0);

      // Reset values after release
      rd_chk(3'd0, 32'hF, "rst_level");
      rd_chk(3'd4, 32'h0, "rst_rise_en");
      rd_chk(3'd5, 32'hF, "rst_fall_en");
      chk("rst_irq", {31'h0, irq}, 32'h0);

      // Fall on channel 0, accepted on edge 6, then clear
      wr_reg(3'd2, 32'h1);
      cur_pin = 4'hE;
      idle(5);
      #1 chk("irq_before_edge6", {31'h0, irq}, 32'h0);
      idle(1);
      #1 chk("irq_at_edge6", {31'h0, irq}, 32'h1);
      rd_chk(3'd0, 32'hE, "level_after_fall");
      rd_chk(3'd3, 32'h1, "cap_after_fall");
      wr_reg(3'd3, 32'h1);
      #1 chk("irq_after_clear", {31'h0, irq}, 32'h0);
      rd_chk(3'd3, 32'h0, "cap_cleared");

      // Short glitch on channel 1 is rejected
      cur_pin = 4'hC;
      idle(3);
      cur_pin = 4'hE;
      idle(8);
      rd_chk(3'd0, 32'hE, "glitch_level");
      rd_chk(3'd3, 32'h0, "glitch_cap");
      chk("glitch_irq", {31'h0, irq}, 32'h0);

      // Rise-only qualification on channel 2
      wr_reg(3'd4, 32'h4);
      wr_reg(3'd5, 32'h0);
      cur_pin = 4'hA;
      idle(10);
      rd_chk(3'd3, 32'h0, "fall_not_captured");
      cur_pin = 4'hE;
      idle(10);
      rd_chk(3'd3, 32'h4, "rise_captured");
      wr_reg(3'd3, 32'h4);

      // Clear and qualifying fall on channel 3 in the same cycle: set wins
      wr_reg(3'd4, 32'h0);
      wr_reg(3'd5, 32'h8);
      cur_pin = 4'h6;
      idle(5);
      wr_reg(3'd3, 32'h8);
      rd_chk(3'd3, 32'h8, "set_beats_clear");

      // Reset in the middle of a debounce count
      wr_reg(3'd2, 32'hF);
      wr_reg(3'd4, 32'hF);
      cur_pin = 4'hE;
      idle(10);
      wr_reg(3'd3, 32'hF);
      cur_pin = 4'hF;
      idle(4);
      @(negedge clk);
      #2 reset_n = 1'b0;
      model_reset();
      #1 chk("midreset_readdata", readdata, 32'h0);
      chk("midreset_irq", {31'h0, irq}, 32'h0);
      for (int k = 0; k < 3; k++) tick(1'b0, 1'b1, 3'd0, 32'h0, 1'b0);
      idle(10);
      rd_chk(3'd0, 32'hF, "post_rst_level");
      rd_chk(3'd2, 32'h0, "post_rst_mask");
      rd_chk(3'd3, 32'h0, "post_rst_cap");
      rd_chk(3'd4, 32'h0, "post_rst_rise");
      rd_chk(3'd5, 32'hF, "post_rst_fall");
      rd_chk(3'd6, 32'h0, "post_rst_status");

      // Random traffic and pin activity against the model
      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(0, 5) == 0) cur_pin = 4'($urandom_range(0, 15));
         tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
              3'($urandom_range(0, 7)), $urandom, 1'b1);
      end

      @(negedge clk);
      #1 chk("sb_drained", sb.size(), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pio_key_debounce_irq.md
PIO_KEY_DEBOUNCE_IRQ -- requirements
Module: pio_key_debounce_irq

Interface
REQ-001 Parameter WIDTH, default 4, number of input channels, legal range 1..32.
REQ-002 Parameter DEBOUNCE_CYCLES, default 16, stable-input cycles required before a level is accepted, legal range 1..65535.
REQ-003 Parameter RESET_LEVEL, default {WIDTH{1'b1}}, reset value of the synchroniser and debounced-level registers.
REQ-004 clk  input  1  rising-edge clock for all logic.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 address  input  3  register select.
REQ-007 chipselect  input  1  slave select.
REQ-008 write_n  input  1  active-low write strobe.
REQ-009 writedata  input  32  write data.
REQ-010 in_port  input  WIDTH  raw asynchronous key inputs.
REQ-011 readdata  output  32  registered read data.
REQ-012 irq  output  1  level interrupt request.

Function
REQ-013 Write strobe = chipselect & ~write_n; writes take effect on the next clk edge.
REQ-014 Register map: 0 debounced level (RO); 1 synchronised raw level (RO); 2 irq_mask (RW); 3 edge_capture (write-1-to-clear); 4 rise_en (RW); 5 fall_en (RW); 6 status (RO; bit0 = irq); 7 reads 0.
REQ-015 Writes to RO addresses 0, 1, 6 and 7 are ignored; RW registers take writedata[WIDTH-1:0].
REQ-016 readdata registers the selected register every clk edge, regardless of chipselect: 1-cycle latency, bits [31:WIDTH] zero.
REQ-017 Each in_port bit passes through a 2-flop synchroniser; the second stage (sync2) is the synchronised raw level.
REQ-018 Per-channel debounce counter, width ceil(log2(DEBOUNCE_CYCLES+1)):
- sync2 == stable: count <= 0.
- Otherwise, count == DEBOUNCE_CYCLES-1: stable <= sync2, count <= 0.
- Otherwise: count <= count+1.
REQ-019 A pin change held constant is reflected in stable on the (DEBOUNCE_CYCLES+2)th clk edge after the change, counting the first capturing edge as edge 1.
REQ-020 A pin pulse shorter than DEBOUNCE_CYCLES cycles at sync2 does not change stable and sets no capture bit.
REQ-021 An accepted update qualifies as follows:
- 0->1 is a rise.
- 1->0 is a fall.
- edge_capture[i] sets on the same edge stable[i] updates, when (rise & rise_en[i]) | (fall & fall_en[i]).
REQ-022 Writing 1 to an edge_capture bit clears that bit; writing 0 leaves it unchanged.
REQ-023 When a clear and a qualifying edge occur on the same bit in the same cycle, the set takes priority and the bit reads 1.
REQ-024 Changing rise_en or fall_en does not alter already-captured bits.
REQ-025 irq = |(edge_capture & irq_mask), combinational from registers with no extra latency; mask changes affect irq the cycle after the write.
REQ-026 Channels are fully independent; simultaneous edges on several channels each set their own bit.

Reset
REQ-027 While reset_n is low:
- readdata, irq_mask, edge_capture, rise_en and all counters = 0.
- fall_en = all ones.
- Synchroniser flops and stable = RESET_LEVEL.
- irq = 0.
REQ-028 Reset asserted mid-debounce abandons the count; no capture bit is set as a result of reset or its release.

Verification (WIDTH=4, DEBOUNCE_CYCLES=4, RESET_LEVEL=4'hF)
REQ-029 Reset, then read addresses 0, 4 and 5 -> readdata 0xF, 0x0 and 0xF on the cycle after each read; irq = 0.
REQ-030 irq_mask=0x1; in_port[0] 1->0 held -> addr0 reads 0xE and edge_capture = 0x1 from edge 6; irq rises after edge 6; write 0x1 to addr3 -> capture 0x0 and irq 0 next cycle.
REQ-031 in_port[1] low for 3 cycles, then high -> stable, edge_capture and irq unchanged.
REQ-032 rise_en=0x4, fall_en=0x0; in_port[2] 1->0->1 with each level held for 10 cycles -> only the rising edge sets capture bit 2; the fall sets nothing.
REQ-033 Write 0x8 to addr3 on the same edge channel 3 accepts a qualifying fall -> edge_capture[3] = 1 afterwards.
REQ-034 Assert reset_n with a counter at 2 mid-debounce -> all registers return to the REQ-027 values; after release with in_port static, no capture bit sets.
